dport_axi4lite: RTL and testbench

- Bridges the core data port (mem_d_* request/accept, ack/resp_tag response) to an AXI4-Lite master.
- Sits directly downstream of riscv_core, in place of or alongside tcm_mem, for peripheral and external memory access.
- Single outstanding transaction.
- Cache-maintenance requests complete locally without a bus transaction.

---
 rtl/dport_axi4lite_pkg.sv | 23 ++
 rtl/dport_axi4lite.sv | 202 ++++++++++++++++++++
 tb/tb_dport_axi4lite.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dport_axi4lite_pkg.sv
// Shared encodings for the data-port to AXI4-Lite bridge.
package dport_axi4lite_pkg;

    // Bridge FSM state encoding (plain constants for legacy tool flows).
    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StWr    = 3'd1;
    localparam state_t StRd    = 3'd2;
    localparam state_t StResp  = 3'd3;
    localparam state_t StDrain = 3'd4;

    // AXI response codes.
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    // SLVERR and DECERR both carry bit 1; EXOKAY is never returned on AXI4-Lite.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/dport_axi4lite.sv
// Core data port to AXI4-Lite master bridge: one outstanding transaction,
// cache-maintenance requests acked locally, optional response timeout.
module dport_axi4lite
    import dport_axi4lite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TAG_W          = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [31:0]      mem_d_addr_i,
    input  logic [31:0]      mem_d_data_wr_i,
    input  logic             mem_d_rd_i,
    input  logic [3:0]       mem_d_wr_i,
    input  logic             mem_d_cacheable_i,
    input  logic [TAG_W-1:0] mem_d_req_tag_i,
    input  logic             mem_d_invalidate_i,
    input  logic             mem_d_writeback_i,
    input  logic             mem_d_flush_i,
    output logic [31:0]      mem_d_data_rd_o,
    output logic             mem_d_accept_o,
    output logic             mem_d_ack_o,
    output logic             mem_d_error_o,
    output logic [TAG_W-1:0] mem_d_resp_tag_o,

    output logic             axi_awvalid_o,
    input  logic             axi_awready_i,
    output logic [31:0]      axi_awaddr_o,
    output logic             axi_wvalid_o,
    input  logic             axi_wready_i,
    output logic [31:0]      axi_wdata_o,
    output logic [3:0]       axi_wstrb_o,
    input  logic             axi_bvalid_i,
    output logic             axi_bready_o,
    input  logic [1:0]       axi_bresp_i,
    output logic             axi_arvalid_o,
    input  logic             axi_arready_i,
    output logic [31:0]      axi_araddr_o,
    input  logic             axi_rvalid_i,
    output logic             axi_rready_o,
    input  logic [31:0]      axi_rdata_i,
    input  logic [1:0]       axi_rresp_i
);

    localparam logic [31:0] TmoLimit = 32'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             arvalid_q, arvalid_d;
    // pend_q: an AXI response is still owed to us, possibly after a timeout ack.
    logic             pend_q, pend_d;
    logic             pend_wr_q, pend_wr_d;
    logic [31:0]      cnt_q, cnt_d;

    logic req, b_done, r_done, tmo_hit;
    logic unused_inputs;

    assign unused_inputs = ^{mem_d_cacheable_i, axi_bresp_i[0], axi_rresp_i[0]};

    assign req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i | mem_d_writeback_i
                 | mem_d_flush_i;

    // A write response only counts once both AW and W have handshaken.
    assign b_done  = pend_q & pend_wr_q & axi_bvalid_i & ~awvalid_q & ~wvalid_q;
    assign r_done  = pend_q & ~pend_wr_q & axi_rvalid_i & ~arvalid_q;
    assign tmo_hit = (TmoLimit != 32'd0) && ((cnt_q + 32'd1) == TmoLimit);

    // Next-state: FSM, capture, channel valids and timeout counter.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        tag_d     = tag_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        awvalid_d = awvalid_q & ~axi_awready_i;
        wvalid_d  = wvalid_q & ~axi_wready_i;
        arvalid_d = arvalid_q & ~axi_arready_i;
        pend_d    = pend_q & ~(b_done | r_done);
        pend_wr_d = pend_wr_q;
        cnt_d     = cnt_q;

        case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = mem_d_addr_i;
                    wdata_d = mem_d_data_wr_i;
                    wstrb_d = mem_d_wr_i;
                    tag_d   = mem_d_req_tag_i;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    cnt_d   = 32'd0;
                    if (|mem_d_wr_i) begin
                        state_d   = StWr;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        pend_d    = 1'b1;
                        pend_wr_d = 1'b1;
                    end else if (mem_d_rd_i) begin
                        state_d   = StRd;
                        arvalid_d = 1'b1;
                        pend_d    = 1'b1;
                        pend_wr_d = 1'b0;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWr: begin
                cnt_d = cnt_q + 32'd1;
                if (b_done) begin
                    state_d = StResp;
                    err_d   = resp_is_err(axi_bresp_i);
                end else if (tmo_hit) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                end
            end
            StRd: begin
                cnt_d = cnt_q + 32'd1;
                if (r_done) begin
                    state_d = StResp;
                    rdata_d = axi_rdata_i;
                    err_d   = resp_is_err(axi_rresp_i);
                end else if (tmo_hit) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                end
            end
            StResp: begin
                // After a timeout the late response must still be swallowed.
                state_d = pend_d ? StDrain : StIdle;
            end
            StDrain: begin
                if (!pend_d) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            tag_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            pend_q    <= 1'b0;
            pend_wr_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            tag_q     <= tag_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mem_d_accept_o   = (state_q == StIdle);
    assign mem_d_ack_o      = (state_q == StResp);
    assign mem_d_error_o    = mem_d_ack_o & err_q;
    assign mem_d_data_rd_o  = rdata_q;
    assign mem_d_resp_tag_o = tag_q;

    assign axi_awvalid_o = awvalid_q;
    assign axi_awaddr_o  = addr_q;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = wstrb_q;
    assign axi_bready_o  = pend_q & pend_wr_q;
    assign axi_arvalid_o = arvalid_q;
    assign axi_araddr_o  = addr_q;
    // rready waits for the AR handshake.
    assign axi_rready_o  = pend_q & ~pend_wr_q & ~arvalid_q;

endmodule

// File: tb/tb_dport_axi4lite.sv
// Bench for dport_axi4lite: programmable AXI slave, directed table, random
// requests checked against a latency/response model, and corner sequences.
module tb_dport_axi4lite;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] d_addr, d_wdata;
    logic        d_rd, d_cache, d_inv, d_wb, d_fl;
    logic [3:0]  d_wr;
    logic [10:0] d_tag;
    logic [31:0] d_rdata;
    logic        d_accept, d_ack, d_err;
    logic [10:0] d_rtag;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    dport_axi4lite #(.TIMEOUT_CYCLES(TMO), .TAG_W(11)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata), .mem_d_rd_i(d_rd),
        .mem_d_wr_i(d_wr), .mem_d_cacheable_i(d_cache), .mem_d_req_tag_i(d_tag),
        .mem_d_invalidate_i(d_inv), .mem_d_writeback_i(d_wb), .mem_d_flush_i(d_fl),
        .mem_d_data_rd_o(d_rdata), .mem_d_accept_o(d_accept), .mem_d_ack_o(d_ack),
        .mem_d_error_o(d_err), .mem_d_resp_tag_o(d_rtag),
        .axi_awvalid_o(awvalid), .axi_awready_i(awready), .axi_awaddr_o(awaddr),
        .axi_wvalid_o(wvalid), .axi_wready_i(wready), .axi_wdata_o(wdata),
        .axi_wstrb_o(wstrb), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
        .axi_bresp_i(bresp), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
        .axi_araddr_o(araddr), .axi_rvalid_i(rvalid), .axi_rready_o(rready),
        .axi_rdata_i(rdata), .axi_rresp_i(rresp)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: no response within cycle budget", nm);
    endtask

    // Slave configuration: extra wait cycles per channel plus response payload.
    int          cfg_aw = 0, cfg_w = 0, cfg_ar = 0, cfg_b = 0, cfg_r = 0;
    logic [1:0]  cfg_resp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;

    // AXI slave: acts on the falling edge; handshakes complete on the next rising edge.
    initial begin
        int  aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        bit  aw_done, w_done, ar_done, hs_aw, hs_w, hs_ar, hs_b, hs_r;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_done = 0; w_done = 0; ar_done = 0;
        hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_done = 0; w_done = 0; ar_done = 0;
                hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
                continue;
            end
            if (hs_aw) begin awready = 0; aw_done = 1; end
            if (hs_w)  begin wready = 0;  w_done = 1;  end
            if (hs_ar) begin arready = 0; ar_done = 1; end
            if (hs_b)  begin bvalid = 0;  aw_done = 0; w_done = 0; end
            if (hs_r)  begin rvalid = 0;  ar_done = 0; end
            if (awvalid && !awready && !aw_done) begin
                if (aw_cnt >= cfg_aw) begin awready = 1; aw_cnt = 0; end else aw_cnt++;
            end
            if (wvalid && !wready && !w_done) begin
                if (w_cnt >= cfg_w) begin wready = 1; w_cnt = 0; end else w_cnt++;
            end
            if (arvalid && !arready && !ar_done) begin
                if (ar_cnt >= cfg_ar) begin arready = 1; ar_cnt = 0; end else ar_cnt++;
            end
            if (aw_done && w_done && !bvalid) begin
                if (b_cnt >= cfg_b) begin bvalid = 1; bresp = cfg_resp; b_cnt = 0; end
                else b_cnt++;
            end
            if (ar_done && !rvalid) begin
                if (r_cnt >= cfg_r) begin
                    rvalid = 1; rdata = cfg_rdata; rresp = cfg_resp; r_cnt = 0;
                end else r_cnt++;
            end
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_ar = arvalid && arready;
            hs_b  = bvalid && bready;
            hs_r  = rvalid && rready;
        end
    end

    // Monitors sample pre-edge values on each rising edge.
    int          cyc = 0, ack_cnt = 0, acc_cnt = 0, vld_cnt = 0, instab = 0;
    logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
    logic [3:0]  cap_wstrb = 0;
    logic        aw_hold = 0, w_hold = 0, ar_hold = 0;
    logic [31:0] awaddr_p = 0, wdata_p = 0, araddr_p = 0;
    logic [3:0]  wstrb_p = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (d_ack) ack_cnt <= ack_cnt + 1;
        if (d_accept) acc_cnt <= acc_cnt + 1;
        if (awvalid || wvalid || arvalid) vld_cnt <= vld_cnt + 1;
        if (awvalid && awready) cap_awaddr <= awaddr;
        if (wvalid && wready) begin cap_wdata <= wdata; cap_wstrb <= wstrb; end
        if (arvalid && arready) cap_araddr <= araddr;
        if ((aw_hold && awvalid && awaddr != awaddr_p) ||
            (w_hold && wvalid && {wdata, wstrb} != {wdata_p, wstrb_p}) ||
            (ar_hold && arvalid && araddr != araddr_p))
            instab <= instab + 1;
        aw_hold <= awvalid && !awready;
        w_hold  <= wvalid && !wready;
        ar_hold <= arvalid && !arready;
        awaddr_p <= awaddr; wdata_p <= wdata; wstrb_p <= wstrb; araddr_p <= araddr;
    end

    typedef struct {
        logic        rd;
        logic [3:0]  wr;
        logic        inv, wb, fl;
        logic [31:0] addr, data;
        logic [10:0] tag;
        int          aw, w, ar, b, r;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] e_data;
        logic        e_err;
        int          e_lat;
    } vec_t;

    function automatic vec_t mkv(input logic rd, input logic [3:0] wr, input logic inv,
                                 input logic wb, input logic fl, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [10:0] tag,
                                 input int aw, input int w, input int ar, input int b,
                                 input int r, input logic [1:0] resp,
                                 input logic [31:0] rd_val, input logic [31:0] e_data,
                                 input logic e_err, input int e_lat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.inv = inv; v.wb = wb; v.fl = fl;
        v.addr = addr; v.data = data; v.tag = tag;
        v.aw = aw; v.w = w; v.ar = ar; v.b = b; v.r = r;
        v.resp = resp; v.rdata = rd_val;
        v.e_data = e_data; v.e_err = e_err; v.e_lat = e_lat;
        return v;
    endfunction

    // Presents a request from a falling edge until accepted; returns capture cycle.
    task automatic do_req(input vec_t v, output int cap);
        cap = -1;
        d_addr = v.addr; d_wdata = v.data; d_rd = v.rd; d_wr = v.wr; d_tag = v.tag;
        d_inv = v.inv; d_wb = v.wb; d_fl = v.fl; d_cache = 1'($urandom_range(0, 1));
        for (int n = 0; n < 200; n++) begin
            if (d_accept) begin cap = cyc; break; end
            @(negedge clk);
        end
        if (cap < 0) bound_fail("req_accept");
        @(negedge clk);
        d_rd = 0; d_wr = 0; d_inv = 0; d_wb = 0; d_fl = 0;
    endtask

    task automatic wait_ack(output int at, output logic [31:0] data, output logic err,
                            output logic [10:0] tag);
        at = -1; data = 0; err = 0; tag = 0;
        for (int n = 0; n < 200; n++) begin
            if (d_ack) begin at = cyc; data = d_rdata; err = d_err; tag = d_rtag; break; end
            @(negedge clk);
        end
        if (at < 0) bound_fail("ack_wait");
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int cap, at, a0, v0;
        logic [31:0] data;
        logic err;
        logic [10:0] tag;
        @(negedge clk);
        cfg_aw = v.aw; cfg_w = v.w; cfg_ar = v.ar; cfg_b = v.b; cfg_r = v.r;
        cfg_resp = v.resp; cfg_rdata = v.rdata;
        a0 = acc_cnt; v0 = vld_cnt;
        do_req(v, cap);
        wait_ack(at, data, err, tag);
        chk({nm, "_data"}, data, v.e_data);
        chk({nm, "_err"}, 32'(err), 32'(v.e_err));
        chk({nm, "_tag"}, 32'(tag), 32'(v.tag));
        chk({nm, "_lat"}, 32'(at - cap), 32'(v.e_lat));
        chk({nm, "_accept_cycles"}, 32'(acc_cnt - a0), 32'd1);
        if (|v.wr) begin
            chk({nm, "_awaddr"}, cap_awaddr, v.addr);
            chk({nm, "_wdata"}, cap_wdata, v.data);
            chk({nm, "_wstrb"}, 32'(cap_wstrb), 32'(v.wr));
        end else if (v.rd) begin
            chk({nm, "_araddr"}, cap_araddr, v.addr);
        end else begin
            chk({nm, "_no_axi_valid"}, 32'(vld_cnt - v0), 32'd0);
        end
    endtask

    vec_t tbl[6];

    initial begin
        vec_t        v, v2;
        int          cap, cap2, at, at2, a0, k0, is_wr, is_rd, mx;
        logic [31:0] data;
        logic        err;
        logic [10:0] tag, tag2;

        tbl[0] = mkv(1, 4'h0, 0, 0, 0, 32'h8000_1000, 32'h0, 11'h02A,
                     0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 3);
        tbl[1] = mkv(0, 4'b0011, 0, 0, 0, 32'h8000_0010, 32'h1234_5678, 11'h011,
                     3, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 1, 6);
        tbl[2] = mkv(0, 4'h0, 0, 0, 1, 32'h0000_0040, 32'h0, 11'h7FF,
                     0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 1);
        tbl[3] = mkv(1, 4'h0, 0, 0, 0, 32'h0000_2000, 32'h0, 11'h155,
                     0, 0, 1, 0, 2, 2'b11, 32'h1122_3344, 32'h1122_3344, 1, 6);
        tbl[4] = mkv(1, 4'hF, 0, 0, 0, 32'h0000_3004, 32'hCAFE_F00D, 11'h003,
                     0, 2, 0, 1, 0, 2'b00, 32'h5555_5555, 32'h0, 0, 6);
        tbl[5] = mkv(0, 4'h0, 1, 1, 0, 32'h0000_0080, 32'h0, 11'h400,
                     0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 1);

        rst_n = 0;
        d_addr = 0; d_wdata = 0; d_rd = 0; d_wr = 0; d_cache = 0; d_tag = 0;
        d_inv = 0; d_wb = 0; d_fl = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(d_ack), 32'd0);
        chk("rst_error", 32'(d_err), 32'd0);
        chk("rst_data_rd", d_rdata, 32'd0);
        chk("rst_resp_tag", 32'(d_rtag), 32'd0);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_accept", 32'(d_accept), 32'd1);

        for (int i = 0; i < 6; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);
        chk("addr_data_stable", 32'(instab), 32'd0);

        // Random requests against the response/latency model.
        for (int i = 0; i < 24; i++) begin
            v.addr = $urandom; v.data = $urandom; v.tag = 11'($urandom);
            v.rdata = $urandom; v.resp = 2'($urandom_range(0, 3));
            v.aw = $urandom_range(0, 2); v.w = $urandom_range(0, 2);
            v.ar = $urandom_range(0, 2); v.b = $urandom_range(0, 2);
            v.r = $urandom_range(0, 2);
            v.rd = 0; v.wr = 0; v.inv = 0; v.wb = 0; v.fl = 0;
            case ($urandom_range(0, 2))
                0: begin v.wr = 4'($urandom_range(1, 15)); v.rd = 1'($urandom_range(0, 1)); end
                1: v.rd = 1;
                default: begin
                    v.inv = 1'($urandom_range(0, 1)); v.wb = 1'($urandom_range(0, 1));
                    v.fl = ~(v.inv | v.wb) | 1'($urandom_range(0, 1));
                end
            endcase
            is_wr = (v.wr != 0) ? 1 : 0;
            is_rd = (!is_wr && v.rd) ? 1 : 0;
            mx = (v.aw > v.w) ? v.aw : v.w;
            v.e_data = is_rd ? v.rdata : 32'h0;
            v.e_err  = (is_wr || is_rd) ? (v.resp >= 2'b10) : 1'b0;
            v.e_lat  = is_wr ? 3 + mx + v.b : (is_rd ? 3 + v.ar + v.r : 1);
            run_vec($sformatf("rnd%0d", i), v);
        end
        chk("rnd_addr_data_stable", 32'(instab), 32'd0);

        // Back-to-back reads: second request waits for accept after the first ack.
        @(negedge clk);
        cfg_aw = 0; cfg_w = 0; cfg_ar = 0; cfg_b = 0; cfg_r = 0; cfg_resp = 0;
        v = tbl[0]; v.tag = 11'h101;
        v2 = tbl[0]; v2.tag = 11'h202; v2.addr = 32'h8000_1004;
        fork
            begin do_req(v, cap); do_req(v2, cap2); end
            begin
                wait_ack(at, data, err, tag);
                @(negedge clk);
                wait_ack(at2, data, err, tag2);
            end
        join
        chk("b2b_tag1", 32'(tag), 32'h101);
        chk("b2b_tag2", 32'(tag2), 32'h202);
        chk("b2b_second_capture", 32'(cap2 - at), 32'd1);
        chk("b2b_second_lat", 32'(at2 - cap2), 32'd3);

        // Timeout: AR accepted, R withheld past the limit, then drained.
        @(negedge clk);
        cfg_r = 27; cfg_rdata = 32'hA5A5_A5A5;
        k0 = ack_cnt;
        v = tbl[0]; v.tag = 11'h0F0;
        do_req(v, cap);
        wait_ack(at, data, err, tag);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_lat", 32'(at - cap), 32'(TMO + 1));
        chk("tmo_tag", 32'(tag), 32'h0F0);
        chk("tmo_data", data, 32'd0);
        a0 = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (d_accept) begin a0 = cyc; break; end
        end
        if (a0 < 0) bound_fail("tmo_drain");
        else chk("tmo_accept_return", 32'(a0 - cap), 32'd30);
        repeat (5) @(negedge clk);
        chk("tmo_single_ack", 32'(ack_cnt - k0), 32'd1);
        cfg_r = 0;

        // Reset with AW pending: valids clear at once, no ack afterwards.
        cfg_aw = 50;
        do_req(tbl[1], cap);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_valids", 32'({awvalid, wvalid, arvalid}), 32'd0);
        chk("rst_mid_ack", 32'(d_ack), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        cfg_aw = 0;
        k0 = ack_cnt;
        @(negedge clk);
        chk("rst_mid_accept", 32'(d_accept), 32'd1);
        repeat (10) @(negedge clk);
        chk("rst_mid_no_ack", 32'(ack_cnt - k0), 32'd0);
        chk("rst_mid_no_valid", 32'({awvalid, wvalid, arvalid}), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
